// File: rtl/mips_mem_pkg.sv
// Shared memory-access encodings for the MIPS core's load/store port.
// Used by the control unit and by the data-memory responder.
package mips_mem_pkg;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LHU = 3'd2;
  localparam logic [2:0] LD_LB  = 3'd3;
  localparam logic [2:0] LD_LBU = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_t;

  // Stores take their width from size, loads from the load type; aw is the word-address width.
  function automatic logic dm_illegal(input logic        we,
                                      input logic [1:0]  size,
                                      input logic [2:0]  ld,
                                      input logic [31:0] addr,
                                      input int unsigned aw);
    logic is_word;
    logic is_half;
    logic bad_code;
    if (we) begin
      is_word  = (size == SZ_WORD);
      is_half  = (size == SZ_HALF);
      bad_code = (size > SZ_BYTE);
    end else begin
      is_word  = (ld == LD_LW);
      is_half  = (ld == LD_LH) || (ld == LD_LHU);
      bad_code = (ld > LD_LBU);
    end
    return bad_code
        || (is_word && (addr[1:0] != 2'b00))
        || (is_half && addr[0])
        || ((addr >> (aw + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Load/store request/response channel between the core's memory stage and the data memory.
interface dm_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic [2:0]  req_load;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_load, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_load, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: merges store data into the old word and extracts/extends load data.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [2:0]  load_i,
  input  logic [1:0]  byte_off_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o
);

  logic [4:0]  bit_off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign bit_off = {byte_off_i, 3'b000};

  always_comb begin
    merged_o = old_word_i;
    case (size_i)
      SZ_WORD: merged_o = wdata_i;
      SZ_HALF: begin
        if (byte_off_i[1]) merged_o[31:16] = wdata_i[15:0];
        else               merged_o[15:0]  = wdata_i[15:0];
      end
      SZ_BYTE: merged_o[bit_off +: 8] = wdata_i[7:0];
      default: merged_o = old_word_i;
    endcase
  end

  always_comb begin
    byte_sel = old_word_i[bit_off +: 8];
    half_sel = byte_off_i[1] ? old_word_i[31:16] : old_word_i[15:0];
    case (load_i)
      LD_LW:   load_o = old_word_i;
      LD_LH:   load_o = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  load_o = {16'd0, half_sel};
      LD_LB:   load_o = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  load_o = {24'd0, byte_sel};
      default: load_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one access at a time, programmable wait states, lane merge/extract,
// and misaligned / out-of-range / reserved-code error reporting.
module dm_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset,
  dm_responder_if.slave bus
);

  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [3:0] LAT4  = 4'(LATENCY);

  dm_state_t           state_q;
  logic [3:0]          cnt_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [31:0]         rsp_rdata_q;

  logic                we_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [1:0]          size_q;
  logic [2:0]          load_q;

  logic [31:0]         mem_q [DEPTH];

  logic                accept;
  logic                illegal;
  logic                access;
  logic                acc_we;
  logic [ADDR_W+1:0]   acc_addr;
  logic [31:0]         acc_wdata;
  logic [1:0]          acc_size;
  logic [2:0]          acc_load;
  logic [31:0]         old_word;
  logic [31:0]         merged_word;
  logic [31:0]         load_word;

  assign accept  = (state_q == IDLE) && req_ready_q && bus.req_valid;
  assign illegal = dm_illegal(bus.req_we, bus.req_size, bus.req_load, bus.req_addr, ADDR_W);
  // With zero latency the access is performed on the acceptance edge from the live request.
  assign access  = (accept && !illegal && (LATENCY == 0))
                || ((state_q == WAIT) && (cnt_q == 4'd1));

  always_comb begin
    if (state_q == IDLE) begin
      acc_we    = bus.req_we;
      acc_addr  = bus.req_addr[ADDR_W+1:0];
      acc_wdata = bus.req_wdata;
      acc_size  = bus.req_size;
      acc_load  = bus.req_load;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_size  = size_q;
      acc_load  = load_q;
    end
  end

  assign old_word = mem_q[acc_addr[ADDR_W+1:2]];

  mem_lane_align u_align (
    .old_word_i (old_word),
    .wdata_i    (acc_wdata),
    .size_i     (acc_size),
    .load_i     (acc_load),
    .byte_off_i (acc_addr[1:0]),
    .merged_o   (merged_word),
    .load_o     (load_word)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr[ADDR_W+1:0];
      wdata_q <= bus.req_wdata;
      size_q  <= bus.req_size;
      load_q  <= bus.req_load;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (access && acc_we) begin
      mem_q[acc_addr[ADDR_W+1:2]] <= merged_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            req_ready_q <= 1'b0;
            if (illegal) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 32'd0;
            end else if (LATENCY == 0) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= acc_we ? 32'd0 : load_word;
            end else begin
              cnt_q   <= LAT4;
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd1) begin
            cnt_q       <= 4'd0;
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= acc_we ? 32'd0 : load_word;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: byte-array reference model, random and directed traffic.
module tb_dm_responder;
  import mips_mem_pkg::*;

  localparam int ADDR_W = 10;
  localparam int LAT    = 2;
  localparam int MEMB   = 4 << ADDR_W;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   rr_mode = 0;
  exp_t sbq[$];
  logic [7:0] mem_m [MEMB];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_responder_if bus();
  dm_responder_if bus0();

  dm_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  dm_responder #(.ADDR_W(ADDR_W), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < MEMB; i++) mem_m[i] = 8'h00;
  endtask

  // Little-endian byte-array view of the memory.
  task automatic model(input logic we, input logic [1:0] size, input logic [2:0] ld,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
    int n;
    logic [31:0] v;
    if (we) n = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : (size == 2'd2) ? 1 : 0;
    else    n = (ld == 3'd0) ? 4 : (ld == 3'd1 || ld == 3'd2) ? 2 : (ld == 3'd3 || ld == 3'd4) ? 1 : 0;
    if (n == 0) err = 1'b1;
    else        err = (addr >= 32'(MEMB)) || ((addr % 32'(n)) != 32'd0);
    rd = 32'd0;
    v  = 32'd0;
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        if (we) mem_m[addr + 32'(i)] = wd[8*i +: 8];
        else    v[8*i +: 8] = mem_m[addr + 32'(i)];
      end
      if (!we) begin
        if (ld == 3'd1 && v[15]) v[31:16] = 16'hFFFF;
        if (ld == 3'd3 && v[7])  v[31:8]  = 24'hFFFFFF;
        rd = v;
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic [2:0] ld,
                        input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_load  = ld;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    while (!bus.req_ready && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_accept_timeout actual=req_ready_low required=accept_within_60");
      bus.req_valid = 1'b0;
      return;
    end
    model(we, size, ld, addr, wd, e.rdata, e.err);
    e.due = cyc + (e.err ? 1 : LAT + 1);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom());
    bus.req_addr  = $urandom();
    bus.req_wdata = $urandom();
    bus.req_size  = 2'($urandom());
    bus.req_load  = 3'($urandom());
  endtask

  task automatic drain();
    int guard = 0;
    @(negedge clk);
    while ((sbq.size() != 0 || !bus.req_ready) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sbq.size() != 0 || !bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=pending_%0d required=idle", sbq.size());
    end
  endtask

  // rsp_ready changes just after the rising edge so the monitor sees a settled value.
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rr_mode)
        0:       bus.rsp_ready = 1'b1;
        1:       bus.rsp_ready = ($urandom_range(0, 3) != 0);
        default: bus.rsp_ready = 1'b0;
      endcase
    end
  end

  logic        prev_v = 1'b0;
  logic        prev_hs = 1'b0;
  logic [31:0] held_d = 32'd0;
  logic        held_e = 1'b0;
  exp_t        cur;

  always @(negedge clk) begin
    if (!reset) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) begin
        check("ready_after_hs", 32'(bus.req_ready), 32'd1);
        check("valid_drop_after_hs", 32'(bus.rsp_valid), 32'd0);
      end
      if (bus.rsp_valid) begin
        check("no_overlap", 32'(bus.req_ready), 32'd0);
        if (!prev_v) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp actual=rsp_valid required=no_response");
          end else begin
            cur = sbq.pop_front();
            check("rsp_rdata", bus.rsp_rdata, cur.rdata);
            check("rsp_err", 32'(bus.rsp_err), 32'(cur.err));
            check("rsp_latency", cyc, cur.due);
          end
        end else begin
          check("rdata_stable", bus.rsp_rdata, held_d);
          check("err_stable", 32'(bus.rsp_err), 32'(held_e));
        end
        held_d = bus.rsp_rdata;
        held_e = bus.rsp_err;
      end
      prev_hs = bus.rsp_valid && bus.rsp_ready;
      prev_v  = bus.rsp_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d0;
    logic [31:0] a;
    logic [1:0]  sz;
    logic [2:0]  ld;
    int          guard;
    int          r;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.req_size   = 2'd0;
    bus.req_load   = 3'd0;
    bus0.req_valid = 1'b0;
    bus0.req_we    = 1'b0;
    bus0.req_addr  = 32'd0;
    bus0.req_wdata = 32'd0;
    bus0.req_size  = 2'd0;
    bus0.req_load  = 3'd0;
    bus0.rsp_ready = 1'b1;
    clear_model();

    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ready", 32'(bus.req_ready), 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'(bus.req_ready), 32'd1);

    // Zero-latency instance: sw then lw back to back.
    d0 = $urandom();
    guard = 0;
    while (!bus0.req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    bus0.req_valid = 1'b1;
    bus0.req_we    = 1'b1;
    bus0.req_size  = SZ_WORD;
    bus0.req_addr  = 32'h40;
    bus0.req_wdata = d0;
    @(negedge clk);
    check("l0_sw_valid", 32'(bus0.rsp_valid), 32'd1);
    check("l0_sw_err", 32'(bus0.rsp_err), 32'd0);
    check("l0_sw_rdata", bus0.rsp_rdata, 32'd0);
    bus0.req_we   = 1'b0;
    bus0.req_load = LD_LW;
    @(negedge clk);
    check("l0_idle_ready", 32'(bus0.req_ready), 32'd1);
    check("l0_idle_valid", 32'(bus0.rsp_valid), 32'd0);
    @(negedge clk);
    bus0.req_valid = 1'b0;
    check("l0_lw_valid", 32'(bus0.rsp_valid), 32'd1);
    check("l0_lw_rdata", bus0.rsp_rdata, d0);
    check("l0_lw_err", 32'(bus0.rsp_err), 32'd0);

    // Directed round-trip, lanes and errors.
    do_req(1'b1, SZ_WORD, LD_LW,  32'h10, 32'h12345678);
    do_req(1'b0, SZ_WORD, LD_LW,  32'h10, 32'h0);
    do_req(1'b1, SZ_WORD, LD_LW,  32'h20, 32'h0);
    do_req(1'b1, SZ_BYTE, LD_LW,  32'h23, 32'h000000AB);
    do_req(1'b1, SZ_HALF, LD_LW,  32'h20, 32'h00008001);
    do_req(1'b0, SZ_WORD, LD_LW,  32'h20, 32'h0);
    do_req(1'b0, SZ_WORD, LD_LB,  32'h23, 32'h0);
    do_req(1'b0, SZ_WORD, LD_LBU, 32'h23, 32'h0);
    do_req(1'b0, SZ_WORD, LD_LH,  32'h20, 32'h0);
    do_req(1'b0, SZ_WORD, LD_LHU, 32'h22, 32'h0);
    do_req(1'b0, SZ_WORD, LD_LW,  32'h22, 32'h0);
    do_req(1'b1, SZ_HALF, LD_LW,  32'h21, 32'hFFFF);
    do_req(1'b0, SZ_WORD, LD_LW,  32'h20, 32'h0);
    do_req(1'b1, SZ_WORD, LD_LW,  32'h1000, 32'hCAFEF00D);
    do_req(1'b1, 2'd3,    LD_LW,  32'h24, 32'h1);
    do_req(1'b0, SZ_WORD, 3'd6,   32'h24, 32'h0);
    do_req(1'b0, SZ_WORD, LD_LW,  32'h24, 32'h0);
    drain();

    // Backpressure: response held with rsp_ready low.
    rr_mode = 2;
    do_req(1'b0, SZ_WORD, LD_LW, 32'h10, 32'h0);
    guard = 0;
    while (!bus.rsp_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    repeat (5) begin
      @(negedge clk);
      check("bp_req_ready_low", 32'(bus.req_ready), 32'd0);
      check("bp_rsp_valid_high", 32'(bus.rsp_valid), 32'd1);
    end
    rr_mode = 0;
    drain();

    // Randomized traffic.
    rr_mode = 1;
    for (int k = 0; k < 160; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom();
      else if (r == 1) a = 32'h0FF8 + 32'($urandom_range(0, 15));
      else             a = 32'($urandom_range(0, 127));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ld = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      do_req(1'($urandom_range(0, 1)), sz, ld, a, $urandom());
    end
    rr_mode = 0;
    drain();

    // Reset while a store is waiting: store dropped, array cleared.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = SZ_WORD;
    bus.req_addr  = 32'h40;
    bus.req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    sbq.delete();
    clear_model();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    do_req(1'b0, SZ_WORD, LD_LW, 32'h40, 32'h0);
    do_req(1'b0, SZ_WORD, LD_LW, 32'h10, 32'h0);
    do_req(1'b0, SZ_WORD, LD_LW, 32'h20, 32'h0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder for the MIPS core: the slave end of the CPU's load/store port, replacing the zero-wait combinational data memory with a request/response handshake and programmable wait states. Accepts one word/half/byte access at a time and performs store lane merging and load extraction/extension. Detects misaligned and out-of-range accesses. Sits between the core's memory stage (address from ALUResult, store data from RD2) and the write-back data mux.

## Interface
- ADDR_W, 10: word-address bits; the array holds 2^ADDR_W 32-bit words.
- LATENCY, 2: wait cycles between acceptance and response for legal accesses; legal range 0..15.

- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; the request is accepted on a rising edge with req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_size  in  2  store size: 0 word, 1 half, 2 byte; 3 is reserved and flagged as an error.
- req_load  in  3  load type: 0 lw, 1 lh, 2 lhu, 3 lb, 4 lbu; 5..7 are reserved and flagged as errors.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  access was misaligned, out of range, or used a reserved code.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:**
  - req_ready=1.
  - On acceptance, latch we, addr, wdata, size and load type.
  - If the access is illegal, go to RESP with err=1.
  - Otherwise, if LATENCY=0, go to RESP; else load the counter with LATENCY and go to WAIT.
- **WAIT:**
  - req_ready=0.
  - Counter decrements each cycle.
  - When the counter is 1, perform the access on that edge and go to RESP.
- **Access edge:**
  - Store: merge the lanes into array word addr[ADDR_W+1:2].
  - Load: register the extracted value into rsp_rdata. It reflects pre-edge contents.
- **RESP:**
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE.
- **Illegal access:** any of the following.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - addr[31:ADDR_W+2]≠0.
  - Reserved size or load code.
  - Illegal accesses never modify the array, and they skip the wait states.
- **Store lanes:**
  - Byte goes to lane addr[1:0], bits 8k+7:8k.
  - Half goes to bits 31:16 if addr[1], else bits 15:0.
  - Word replaces the whole word.
- **Loads:**
  - lb and lh sign-extend; lbu and lhu zero-extend.
  - Byte and half lanes are selected as for stores.

## Timing
- **Reset values** (while reset=0):
  - State IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter 0.
  - Array cleared to zero.
  - After release, req_ready=1.
- **Legal-access latency:** rsp_valid first rises LATENCY+1 cycles after the acceptance cycle (acceptance cycle = 0).
- **Error latency:** rsp_valid rises in cycle 1, regardless of LATENCY.
- **Throughput:** at most one outstanding access. The minimum spacing between acceptances is LATENCY+2 cycles with rsp_ready held high.
- **No overlap:** req_ready is never high while rsp_valid is high; a request cannot be accepted in the response-handshake cycle.
- **Request stability:** request inputs are don't-care outside acceptance cycles.
- **Reset during WAIT or RESP:** the pending access is dropped, no write occurs, and the FSM returns to IDLE.

## Structure
- **Shared package `mips_mem_pkg`:**
  - Size codes SZ_WORD, SZ_HALF, SZ_BYTE.
  - Load codes LD_LW, LD_LH, LD_LHU, LD_LB, LD_LBU.
  - State enum dm_state_t.
  - The package is reused by the core's control unit.
- **Sub-module `mem_lane_align`:** purely combinational. It does two things:
  - Merges the old word with store data per size and addr[1:0].
  - Extracts and extends load data per load type and addr[1:0].
- **Top-level contents:** FSM, counter, array and response registers.

## Test plan
- **Word round-trip:** store word 0x12345678 to 0x10, then lw 0x10 → rsp_rdata=0x12345678, rsp_err=0, with rsp_valid rising 3 cycles after acceptance (LATENCY=2).
- **Byte/half lanes:**
  - Word at 0x20 = 0; sb 0xAB to 0x23 and sh 0x8001 to 0x20; then lw 0x20 → 0xAB008001.
  - lb 0x23 → 0xFFFFFFAB; lbu 0x23 → 0x000000AB; lh 0x20 → 0xFFFF8001.
- **Errors:**
  - lw 0x22 → rsp_err=1 and rsp_rdata=0 in cycle 1.
  - Then sh to 0x21 → err=1, and a following lw shows the word unchanged.
  - Store to 0x1000 (ADDR_W=10) → err=1.
- **Backpressure:**
  - Hold rsp_ready=0 for 5 cycles: rsp_valid and rsp_rdata stay stable and req_ready stays 0.
  - Raise rsp_ready: next cycle IDLE and req_ready=1.
- **LATENCY=0:** back-to-back sw then lw to the same address → responses at cycles 1 and 3, with the lw returning the stored data.
- **Reset mid-WAIT:** drive reset low during a store's WAIT → rsp_valid=0 immediately; after release, lw to that address → 0.
